// File: rtl/demosaic_mul_arbiter.sv
// Round-robin arbiter that lets NUM_REQ requesters share one signed 8x18 multiplier.
// Latency: LATENCY cycles from operand accept to res_valid; one accept per cycle when not stalled.
// Backpressure: res_valid & !res_ready freezes every stage (bubbles included) and drops all req_ready.
// Optional: define DEMOSAIC_MUL_ARB_PRIO0_EN to give requester 0 absolute priority over the round-robin.
module demosaic_mul_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int LATENCY = 2
) (
  input  logic                    ap_clk,
  input  logic                    ap_rst,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [8*NUM_REQ-1:0]    req_a,
  input  logic [18*NUM_REQ-1:0]   req_b,
  output logic [NUM_REQ-1:0]      req_ready,
  output logic                    res_valid,
  output logic [25:0]             res_data,
  output logic [2:0]              res_id,
  input  logic                    res_ready
);

`ifdef DEMOSAIC_MUL_ARB_PRIO0_EN
  localparam bit PRIO0_EN = 1'b1;
`else
  localparam bit PRIO0_EN = 1'b0;
`endif

  logic [2:0]                 last_grant;
  logic [NUM_REQ-1:0]         grant;
  logic [2:0]                 gnt_id;
  logic                       gnt_any;
  logic [3:0]                 idx;
  logic                       adv;
  logic                       acc;
  logic [7:0]                 sel_a;
  logic [17:0]                sel_b;
  logic signed [25:0]         sel_prod;

  // One entry per stage; the last stage drives the result port directly.
  logic [LATENCY-1:0]         stg_vld;
  logic [LATENCY-1:0][2:0]    stg_id;
  logic [LATENCY-1:0][25:0]   stg_prod;

  // The pipeline moves only when the output stage is empty or being drained.
  always_comb begin
    adv = !stg_vld[LATENCY-1] | res_ready;
    acc = adv & gnt_any;
  end

  // Round-robin search starting just after the last accepted requester.
  always_comb begin
    grant   = '0;
    gnt_id  = '0;
    gnt_any = 1'b0;
    idx     = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = {1'b0, last_grant} + 4'(k);
      if (idx >= 4'(NUM_REQ)) idx = idx - 4'(NUM_REQ);
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!gnt_any && idx == 4'(i) && req_valid[i] && (!PRIO0_EN || i != 0)) begin
          grant[i] = 1'b1;
          gnt_id   = 3'(i);
          gnt_any  = 1'b1;
        end
      end
    end
`ifdef DEMOSAIC_MUL_ARB_PRIO0_EN
    if (req_valid[0]) begin
      grant    = '0;
      grant[0] = 1'b1;
      gnt_id   = 3'd0;
      gnt_any  = 1'b1;
    end
`endif
  end

  // Ready is withheld while in reset so nothing is handed over during it.
  always_comb begin
    req_ready = (adv && !ap_rst) ? grant : '0;
  end

  // Operand mux for the granted requester and the full-precision product.
  // 8-bit signed times 18-bit unsigned always fits in 26 signed bits.
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_id == 3'(i)) begin
        sel_a = req_a[8*i +: 8];
        sel_b = req_b[18*i +: 18];
      end
    end
    sel_prod = $signed({{18{sel_a[7]}}, sel_a}) * $signed({8'b0, sel_b});
  end

  // Result port is the output stage.
  always_comb begin
    res_valid = stg_vld[LATENCY-1];
    res_data  = stg_prod[LATENCY-1];
    res_id    = stg_id[LATENCY-1];
  end

  // Stage shift: stage 0 takes the new product (or a bubble), the rest move up.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      stg_vld  <= '0;
      stg_id   <= '0;
      stg_prod <= '0;
    end else if (adv) begin
      stg_vld[0]  <= acc;
      stg_id[0]   <= gnt_id;
      stg_prod[0] <= sel_prod;
      for (int s = 1; s < LATENCY; s++) begin
        stg_vld[s]  <= stg_vld[s-1];
        stg_id[s]   <= stg_id[s-1];
        stg_prod[s] <= stg_prod[s-1];
      end
    end
  end

  // Remember the last round-robin winner; priority-0 accepts do not move it.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      last_grant <= 3'(NUM_REQ - 1);
    end else if (acc && (!PRIO0_EN || gnt_id != 3'd0)) begin
      last_grant <= gnt_id;
    end
  end

endmodule

// File: tb/tb_demosaic_mul_arbiter.sv
module tb_demosaic_mul_arbiter;

  localparam int N   = 4;
  localparam int LAT = 2;
`ifdef DEMOSAIC_MUL_ARB_PRIO0_EN
  localparam bit PRIO0 = 1'b1;
`else
  localparam bit PRIO0 = 1'b0;
`endif

  logic            ap_clk;
  logic            ap_rst;
  logic [N-1:0]    req_valid;
  logic [8*N-1:0]  req_a;
  logic [18*N-1:0] req_b;
  logic [N-1:0]    req_ready;
  logic            res_valid;
  logic [25:0]     res_data;
  logic [2:0]      res_id;
  logic            res_ready;

  demosaic_mul_arbiter #(.NUM_REQ(N), .LATENCY(LAT)) dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
    .res_valid(res_valid), .res_data(res_data), .res_id(res_id), .res_ready(res_ready)
  );

  initial begin
    ap_clk = 1'b0;
    forever #5 ap_clk = ~ap_clk;
  end

  int checks = 0;
  int errors = 0;

  // Reference model: a delay line of LAT results (front = what the port shows)
  // plus the round-robin pointer.
  typedef struct { bit vld; int id; int prod; } ent_t;
  ent_t pipe[$];
  int   mdl_last;
  bit   mdl_adv;
  int   mdl_g;
  logic [N-1:0] exp_ready;
  bit   exp_vld;
  int   exp_id;
  int   exp_prod;

  function automatic void model_reset();
    ent_t b;
    b.vld = 0; b.id = 0; b.prod = 0;
    pipe.delete();
    for (int s = 0; s < LAT; s++) pipe.push_back(b);
    mdl_last = N - 1;
  endfunction

  function automatic int arb(input logic [N-1:0] v);
    if (PRIO0 && v[0]) return 0;
    for (int k = 1; k <= N; k++) begin
      int i;
      i = (mdl_last + k) % N;
      if (!(PRIO0 && i == 0) && v[i]) return i;
    end
    return -1;
  endfunction

  function automatic int prod_of(input int i);
    return int'($signed(req_a[8*i +: 8])) * int'(req_b[18*i +: 18]);
  endfunction

  function automatic void model_eval();
    exp_vld   = pipe[0].vld;
    exp_id    = pipe[0].id;
    exp_prod  = pipe[0].prod;
    mdl_adv   = !exp_vld || res_ready;
    mdl_g     = mdl_adv ? arb(req_valid) : -1;
    exp_ready = (mdl_g >= 0) ? N'(1 << mdl_g) : '0;
  endfunction

  function automatic void model_commit();
    ent_t e;
    if (mdl_adv) begin
      void'(pipe.pop_front());
      e.vld  = (mdl_g >= 0);
      e.id   = (mdl_g >= 0) ? mdl_g : 0;
      e.prod = (mdl_g >= 0) ? prod_of(mdl_g) : 0;
      pipe.push_back(e);
      if (mdl_g >= 0 && !(PRIO0 && mdl_g == 0)) mdl_last = mdl_g;
    end
  endfunction

  task automatic rand_ops();
    req_a = 32'($urandom());
    req_b = 72'({$urandom(), $urandom(), $urandom()});
  endtask

  task automatic set_lane(input int i, input logic [7:0] a, input logic [17:0] b);
    req_a[8*i +: 8]   = a;
    req_b[18*i +: 18] = b;
  endtask

  // Starts and ends on a falling edge; first accept is allowed right after.
  task automatic do_reset();
    ap_rst    = 1'b1;
    req_valid = '0;
    res_ready = 1'b1;
    @(negedge ap_clk);
    ap_rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    ap_rst = 1'b1;
    req_valid = '1;
    rand_ops();
    #1;
    checks += 4;
    if (req_ready !== '0) begin errors++; $display("FAIL reset_req_ready got %b exp 0", req_ready); end
    if (res_valid !== 1'b0) begin errors++; $display("FAIL reset_res_valid got %b exp 0", res_valid); end
    if (res_data !== '0) begin errors++; $display("FAIL reset_res_data got %0d exp 0", res_data); end
    if (res_id !== '0) begin errors++; $display("FAIL reset_res_id got %0d exp 0", res_id); end
    @(negedge ap_clk);
    req_valid = '0;
    ap_rst = 1'b0;
    model_reset();
  endtask

  task automatic test_single_req2();
    do_reset();
    for (int n = 0; n < 6; n++) begin
      rand_ops();
      req_valid = (n == 0) ? 4'b0100 : 4'b0000;
      set_lane(2, 8'h80, 18'h3FFFF);
      #1;
      model_eval();
      checks += 3;
      if (req_ready !== exp_ready) begin errors++; $display("FAIL single_ready cyc %0d got %b exp %b", n, req_ready, exp_ready); end
      if (res_valid !== exp_vld) begin errors++; $display("FAIL single_valid cyc %0d got %b exp %b", n, res_valid, exp_vld); end
      if (exp_vld && (res_id !== 3'(exp_id) || int'($signed(res_data)) !== exp_prod)) begin
        errors++; $display("FAIL single_data cyc %0d got id %0d %0d exp id %0d %0d", n, res_id, $signed(res_data), exp_id, exp_prod);
      end
      if (n == LAT) begin
        checks++;
        if (res_valid !== 1'b1 || res_id !== 3'd2 || int'($signed(res_data)) !== -33554304) begin
          errors++; $display("FAIL single_const got v%b id %0d %0d exp v1 id 2 -33554304", res_valid, res_id, $signed(res_data));
        end
      end
      model_commit();
      @(negedge ap_clk);
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int n = 0; n < 14; n++) begin
      rand_ops();
      req_valid = (n < 12) ? 4'b1111 : 4'b0000;
      #1;
      model_eval();
      checks += 3;
      if (req_ready !== exp_ready) begin errors++; $display("FAIL rr_ready cyc %0d got %b exp %b", n, req_ready, exp_ready); end
      if (res_valid !== exp_vld) begin errors++; $display("FAIL rr_valid cyc %0d got %b exp %b", n, res_valid, exp_vld); end
      if (exp_vld && (res_id !== 3'(exp_id) || int'($signed(res_data)) !== exp_prod)) begin
        errors++; $display("FAIL rr_data cyc %0d got id %0d %0d exp id %0d %0d", n, res_id, $signed(res_data), exp_id, exp_prod);
      end
`ifndef DEMOSAIC_MUL_ARB_PRIO0_EN
      if (n < 12) begin
        checks++;
        if (req_ready !== N'(1 << (n % N))) begin errors++; $display("FAIL rr_sequence cyc %0d got %b exp %0d", n, req_ready, n % N); end
      end
      if (n >= LAT) begin
        checks++;
        if (res_valid !== 1'b1 || res_id !== 3'((n - LAT) % N)) begin
          errors++; $display("FAIL rr_result_order cyc %0d got v%b id %0d exp id %0d", n, res_valid, res_id, (n - LAT) % N);
        end
      end
`endif
      model_commit();
      @(negedge ap_clk);
    end
  endtask

  task automatic test_single_continuous();
    do_reset();
    for (int n = 0; n < 8; n++) begin
      rand_ops();
      req_valid = 4'b1000;
      #1;
      model_eval();
      checks += 2;
      if (req_ready !== 4'b1000) begin errors++; $display("FAIL cont_ready cyc %0d got %b exp 1000", n, req_ready); end
      if (res_valid !== exp_vld || (exp_vld && int'($signed(res_data)) !== exp_prod)) begin
        errors++; $display("FAIL cont_result cyc %0d got v%b %0d exp v%b %0d", n, res_valid, $signed(res_data), exp_vld, exp_prod);
      end
      model_commit();
      @(negedge ap_clk);
    end
  endtask

  task automatic test_stall();
    do_reset();
    for (int n = 0; n < 18; n++) begin
      rand_ops();
      req_valid = (n < 9) ? 4'b1111 : 4'($urandom_range(0, 15)) & {4{n < 12}};
      res_ready = !(n >= 4 && n < 9);
      #1;
      model_eval();
      checks += 3;
      if (req_ready !== exp_ready) begin errors++; $display("FAIL stall_ready cyc %0d got %b exp %b", n, req_ready, exp_ready); end
      if (res_valid !== exp_vld) begin errors++; $display("FAIL stall_valid cyc %0d got %b exp %b", n, res_valid, exp_vld); end
      if (exp_vld && (res_id !== 3'(exp_id) || int'($signed(res_data)) !== exp_prod)) begin
        errors++; $display("FAIL stall_data cyc %0d got id %0d %0d exp id %0d %0d", n, res_id, $signed(res_data), exp_id, exp_prod);
      end
      if (!res_ready) begin
        checks++;
        if (req_ready !== '0) begin errors++; $display("FAIL stall_ready_zero cyc %0d got %b exp 0", n, req_ready); end
      end
      model_commit();
      @(negedge ap_clk);
    end
    res_ready = 1'b1;
  endtask

  task automatic test_pair();
    int got_id[$];
    int got_val[$];
    do_reset();
    for (int n = 0; n < 7; n++) begin
      rand_ops();
      set_lane(1, 8'd127, 18'd3);
      set_lane(3, 8'hFF, 18'd1);
      req_valid = (n == 0) ? 4'b1010 : (n == 1) ? 4'b1000 : 4'b0000;
      #1;
      model_eval();
      checks += 2;
      if (req_ready !== exp_ready) begin errors++; $display("FAIL pair_ready cyc %0d got %b exp %b", n, req_ready, exp_ready); end
      if (res_valid !== exp_vld) begin errors++; $display("FAIL pair_valid cyc %0d got %b exp %b", n, res_valid, exp_vld); end
      if (res_valid && res_ready) begin
        got_id.push_back(int'(res_id));
        got_val.push_back(int'($signed(res_data)));
      end
      model_commit();
      @(negedge ap_clk);
    end
    checks++;
    if (got_id.size() != 2) begin
      errors++; $display("FAIL pair_count got %0d exp 2", got_id.size());
    end else begin
      checks++;
      if (got_id[0] != 1 || got_val[0] != 381 || got_id[1] != 3 || got_val[1] != -1) begin
        errors++; $display("FAIL pair_values got (%0d,%0d),(%0d,%0d) exp (1,381),(3,-1)", got_id[0], got_val[0], got_id[1], got_val[1]);
      end
    end
  endtask

  task automatic test_reset_midflight();
    do_reset();
    for (int n = 0; n < 2; n++) begin
      rand_ops();
      req_valid = 4'b1111;
      #1;
      model_eval();
      model_commit();
      @(negedge ap_clk);
    end
    req_valid = '0;
    #1;
    model_eval();
    checks++;
    if (res_valid !== 1'b1 || !exp_vld) begin errors++; $display("FAIL midrst_inflight got %b exp 1", res_valid); end
    #1;
    ap_rst = 1'b1;
    #1;
    checks += 2;
    if (res_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid got %b exp 0", res_valid); end
    if (req_ready !== '0) begin errors++; $display("FAIL midrst_ready got %b exp 0", req_ready); end
    @(negedge ap_clk);
    ap_rst = 1'b0;
    model_reset();
    for (int n = 0; n < 6; n++) begin
      rand_ops();
      #1;
      model_eval();
      checks++;
      if (res_valid !== 1'b0) begin errors++; $display("FAIL midrst_stale cyc %0d got %b exp 0", n, res_valid); end
      model_commit();
      @(negedge ap_clk);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 400; n++) begin
      rand_ops();
      req_valid = 4'($urandom_range(0, 15));
      res_ready = ($urandom_range(0, 3) != 0);
      #1;
      model_eval();
      checks += 3;
      if (req_ready !== exp_ready) begin errors++; $display("FAIL rand_ready cyc %0d got %b exp %b", n, req_ready, exp_ready); end
      if (res_valid !== exp_vld) begin errors++; $display("FAIL rand_valid cyc %0d got %b exp %b", n, res_valid, exp_vld); end
      if (exp_vld && (res_id !== 3'(exp_id) || int'($signed(res_data)) !== exp_prod)) begin
        errors++; $display("FAIL rand_data cyc %0d got id %0d %0d exp id %0d %0d", n, res_id, $signed(res_data), exp_id, exp_prod);
      end
      model_commit();
      @(negedge ap_clk);
    end
    res_ready = 1'b1;
  endtask

`ifdef DEMOSAIC_MUL_ARB_PRIO0_EN
  task automatic test_prio0();
    do_reset();
    for (int n = 0; n < 8; n++) begin
      rand_ops();
      req_valid = 4'b0011;
      #1;
      checks++;
      if (req_ready !== 4'b0001) begin errors++; $display("FAIL prio0_ready cyc %0d got %b exp 0001", n, req_ready); end
      model_eval();
      model_commit();
      @(negedge ap_clk);
    end
  endtask
`endif

  initial begin
    ap_rst    = 1'b1;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    res_ready = 1'b1;
    model_reset();
    #12;
    @(negedge ap_clk);
    test_reset();
    test_single_req2();
    test_round_robin();
    test_single_continuous();
    test_stall();
    test_pair();
    test_reset_midflight();
    test_random();
`ifdef DEMOSAIC_MUL_ARB_PRIO0_EN
    test_prio0();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
